// File: rtl/mc_main_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state encodings, mux selector codes.
// Also holds the flat control word that the output decoder hands to the top.
package mc_main_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  localparam logic [1:0] ASB_RT     = 2'd0;
  localparam logic [1:0] ASB_FOUR   = 2'd1;
  localparam logic [1:0] ASB_IMM    = 2'd2;
  localparam logic [1:0] ASB_IMM_SH = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic       pc_cond;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the instruction register / memory handshake and the datapath.
// master drives opcode and mem_ready; slave (the controller) drives every control output.
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       lw;
  logic       sw;
  logic       beq;
  logic       rtype;
  logic       pc_we;
  logic       pc_cond;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_re;
  logic       mem_we;
  logic       iord;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    output opcode, mem_ready,
    input  lw, sw, beq, rtype, pc_we, pc_cond, pc_src, ir_we, mem_re, mem_we, iord,
           reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, illegal, state_o
  );

  modport slave (
    input  opcode, mem_ready,
    output lw, sw, beq, rtype, pc_we, pc_cond, pc_src, ir_we, mem_re, mem_we, iord,
           reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, illegal, state_o
  );
endinterface

// File: rtl/mc_main_ctrl_out_decode.sv
// Combinational state -> control word decode; zero latency, no backpressure of its own.
// Only FETCH write enables look at mem_ready, and only DECODE looks at the opcode.
import mc_main_ctrl_pkg::*;

module mc_main_ctrl_out_decode (
  input  state_e      i_state,
  input  logic        i_mem_ready,
  input  logic [5:0]  i_opcode,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_re    = 1'b1;
        o_ctrl.alu_src_b = ASB_FOUR;
        o_ctrl.pc_src    = PCS_ALU;
        // Gate on mem_ready so a stalled fetch never double-increments the PC.
        o_ctrl.ir_we     = i_mem_ready;
        o_ctrl.pc_we     = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = ASB_IMM_SH;
        o_ctrl.illegal   = !op_supported(i_opcode);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_re = 1'b1;
        o_ctrl.iord   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_we     = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_we = 1'b1;
        o_ctrl.iord   = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_RT;
      end
      S_ALUWB: begin
        o_ctrl.reg_we  = 1'b1;
        o_ctrl.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_RT;
        o_ctrl.pc_cond   = 1'b1;
        o_ctrl.pc_src    = PCS_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_we  = 1'b1;
        o_ctrl.pc_src = PCS_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS-subset main control FSM; Moore outputs from the state register, class flags latched at DECODE.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; CPI R=4 lw=5 sw=4 beq=3 j=3 plus one per wait cycle.
import mc_main_ctrl_pkg::*;

module mc_main_ctrl (
  input  logic             clk,
  input  logic             rst,
  mc_main_ctrl_if.slave    bus
);

  state_e r_state;
  logic   r_lw;
  logic   r_sw;
  logic   r_beq;
  logic   r_rtype;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lw    <= 1'b0;
      r_sw    <= 1'b0;
      r_beq   <= 1'b0;
      r_rtype <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_lw    <= (bus.opcode == OP_LW);
          r_sw    <= (bus.opcode == OP_SW);
          r_beq   <= (bus.opcode == OP_BEQ);
          r_rtype <= (bus.opcode == OP_RTYPE);
          case (bus.opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= r_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default: begin
          // Stray encodings recover through IDLE with a clean flag set.
          r_state <= S_IDLE;
          r_lw    <= 1'b0;
          r_sw    <= 1'b0;
          r_beq   <= 1'b0;
          r_rtype <= 1'b0;
        end
      endcase
    end
  end

  mc_main_ctrl_out_decode u_out_decode (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
    .i_opcode    (bus.opcode),
    .o_ctrl      (w_ctrl)
  );

  assign bus.lw         = r_lw;
  assign bus.sw         = r_sw;
  assign bus.beq        = r_beq;
  assign bus.rtype      = r_rtype;
  assign bus.pc_we      = w_ctrl.pc_we;
  assign bus.pc_cond    = w_ctrl.pc_cond;
  assign bus.pc_src     = w_ctrl.pc_src;
  assign bus.ir_we      = w_ctrl.ir_we;
  assign bus.mem_re     = w_ctrl.mem_re;
  assign bus.mem_we     = w_ctrl.mem_we;
  assign bus.iord       = w_ctrl.iord;
  assign bus.reg_we     = w_ctrl.reg_we;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.illegal    = w_ctrl.illegal;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: per-cycle expected {state, flags, control word} vectors.
// Observed word layout: state[22:19] {lw,sw,beq,rtype}[18:15] control[14:0].
import mc_main_ctrl_pkg::*;

module tb_mc_main_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mc_main_ctrl_if bus ();

  mc_main_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: pc_we pc_cond pc_src ir_we mem_re mem_we iord reg_we reg_dst mem_to_reg alu_src_a alu_src_b illegal
  localparam logic [14:0] C_ZERO   = 15'b0_0_00_0_0_0_0_0_0_0_0_00_0;
  localparam logic [14:0] C_FWAIT  = 15'b0_0_00_0_1_0_0_0_0_0_0_01_0;
  localparam logic [14:0] C_FGO    = 15'b1_0_00_1_1_0_0_0_0_0_0_01_0;
  localparam logic [14:0] C_DEC    = 15'b0_0_00_0_0_0_0_0_0_0_0_11_0;
  localparam logic [14:0] C_DECILL = 15'b0_0_00_0_0_0_0_0_0_0_0_11_1;
  localparam logic [14:0] C_MEMADR = 15'b0_0_00_0_0_0_0_0_0_0_1_10_0;
  localparam logic [14:0] C_MEMRD  = 15'b0_0_00_0_1_0_1_0_0_0_0_00_0;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_00_0_0_0_0_1_0_1_0_00_0;
  localparam logic [14:0] C_MEMWR  = 15'b0_0_00_0_0_1_1_0_0_0_0_00_0;
  localparam logic [14:0] C_EXEC   = 15'b0_0_00_0_0_0_0_0_0_0_1_00_0;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_00_0_0_0_0_1_1_0_0_00_0;
  localparam logic [14:0] C_BRANCH = 15'b0_1_01_0_0_0_0_0_0_0_1_00_0;
  localparam logic [14:0] C_JUMP   = 15'b1_0_10_0_0_0_0_0_0_0_0_00_0;

  wire [22:0] w_obs = {bus.state_o, bus.lw, bus.sw, bus.beq, bus.rtype,
                       bus.pc_we, bus.pc_cond, bus.pc_src, bus.ir_we, bus.mem_re, bus.mem_we,
                       bus.iord, bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                       bus.alu_src_b, bus.illegal};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    tick();
    n_total++;
    if (w_obs !== 23'd0) $display("FAIL reset_held got %h want %h", w_obs, 23'd0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (w_obs !== 23'd0) $display("FAIL reset_idle got %h want %h", w_obs, 23'd0);
    else n_pass++;
    tick();
    n_total++;
    if (w_obs !== {4'd1, 4'b0000, C_FWAIT})
      $display("FAIL reset_to_fetch got %h want %h", w_obs, {4'd1, 4'b0000, C_FWAIT});
    else n_pass++;
  endtask

  task automatic test_lw();
    logic [6:0]  in_v [6];
    logic [22:0] ex_v [6];
    in_v = '{{1'b1, OP_LW}, {1'b1, OP_LW}, {1'b1, OP_LW},
             {1'b1, OP_LW}, {1'b1, OP_LW}, {1'b1, OP_LW}};
    ex_v = '{{4'd1, 4'b0000, C_FGO},  {4'd2, 4'b0000, C_DEC},
             {4'd3, 4'b1000, C_MEMADR}, {4'd4, 4'b1000, C_MEMRD},
             {4'd5, 4'b1000, C_MEMWB}, {4'd1, 4'b1000, C_FGO}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.mem_ready = in_v[i][6];
      bus.opcode    = in_v[i][5:0];
      #1;
      n_total++;
      if (w_obs !== ex_v[i]) $display("FAIL lw[%0d] got %h want %h", i, w_obs, ex_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_wait_rtype();
    logic [6:0]  in_v [8];
    logic [22:0] ex_v [8];
    in_v = '{{1'b0, OP_RTYPE}, {1'b0, OP_RTYPE}, {1'b0, OP_RTYPE}, {1'b1, OP_RTYPE},
             {1'b0, OP_RTYPE}, {1'b0, OP_RTYPE}, {1'b0, OP_RTYPE}, {1'b1, OP_RTYPE}};
    ex_v = '{{4'd1, 4'b0000, C_FWAIT}, {4'd1, 4'b0000, C_FWAIT},
             {4'd1, 4'b0000, C_FWAIT}, {4'd1, 4'b0000, C_FGO},
             {4'd2, 4'b0000, C_DEC},   {4'd7, 4'b0001, C_EXEC},
             {4'd8, 4'b0001, C_ALUWB}, {4'd1, 4'b0001, C_FGO}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.mem_ready = in_v[i][6];
      bus.opcode    = in_v[i][5:0];
      #1;
      n_total++;
      if (w_obs !== ex_v[i]) $display("FAIL fetch_rtype[%0d] got %h want %h", i, w_obs, ex_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_beq_jump();
    logic [6:0]  in_v [7];
    logic [22:0] ex_v [7];
    in_v = '{{1'b1, OP_BEQ}, {1'b1, OP_BEQ}, {1'b1, OP_BEQ}, {1'b1, OP_J},
             {1'b1, OP_J},   {1'b1, OP_J},   {1'b0, OP_J}};
    ex_v = '{{4'd1, 4'b0000, C_FGO},    {4'd2, 4'b0000, C_DEC},
             {4'd9, 4'b0010, C_BRANCH}, {4'd1, 4'b0010, C_FGO},
             {4'd2, 4'b0010, C_DEC},    {4'd10, 4'b0000, C_JUMP},
             {4'd1, 4'b0000, C_FWAIT}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.mem_ready = in_v[i][6];
      bus.opcode    = in_v[i][5:0];
      #1;
      n_total++;
      if (w_obs !== ex_v[i]) $display("FAIL beq_j[%0d] got %h want %h", i, w_obs, ex_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sw_illegal();
    logic [6:0]  in_v [9];
    logic [22:0] ex_v [9];
    in_v = '{{1'b1, OP_SW}, {1'b1, OP_SW}, {1'b1, OP_SW}, {1'b0, OP_SW}, {1'b0, OP_SW},
             {1'b1, OP_SW}, {1'b1, 6'h3f}, {1'b1, 6'h3f}, {1'b0, 6'h3f}};
    ex_v = '{{4'd1, 4'b0000, C_FGO},    {4'd2, 4'b0000, C_DEC},
             {4'd3, 4'b0100, C_MEMADR}, {4'd6, 4'b0100, C_MEMWR},
             {4'd6, 4'b0100, C_MEMWR},  {4'd6, 4'b0100, C_MEMWR},
             {4'd1, 4'b0100, C_FGO},    {4'd2, 4'b0100, C_DECILL},
             {4'd1, 4'b0000, C_FWAIT}};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.mem_ready = in_v[i][6];
      bus.opcode    = in_v[i][5:0];
      #1;
      n_total++;
      if (w_obs !== ex_v[i]) $display("FAIL sw_illegal[%0d] got %h want %h", i, w_obs, ex_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid_memrd();
    logic [6:0]  in_v [5];
    logic [22:0] ex_v [5];
    in_v = '{{1'b1, OP_LW}, {1'b1, OP_LW}, {1'b1, OP_LW}, {1'b0, OP_LW}, {1'b0, OP_LW}};
    ex_v = '{{4'd1, 4'b0000, C_FGO},    {4'd2, 4'b0000, C_DEC},
             {4'd3, 4'b1000, C_MEMADR}, {4'd4, 4'b1000, C_MEMRD},
             {4'd4, 4'b1000, C_MEMRD}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.mem_ready = in_v[i][6];
      bus.opcode    = in_v[i][5:0];
      #1;
      n_total++;
      if (w_obs !== ex_v[i]) $display("FAIL rst_mid[%0d] got %h want %h", i, w_obs, ex_v[i]);
      else n_pass++;
    end
    rst = 1'b1;
    #1;
    n_total++;
    if (w_obs !== 23'd0) $display("FAIL rst_mid_async got %h want %h", w_obs, 23'd0);
    else n_pass++;
    tick();
    n_total++;
    if (w_obs !== 23'd0) $display("FAIL rst_mid_held got %h want %h", w_obs, 23'd0);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (w_obs !== {4'd1, 4'b0000, C_FWAIT})
      $display("FAIL rst_mid_release got %h want %h", w_obs, {4'd1, 4'b0000, C_FWAIT});
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    test_reset();
    test_lw();
    test_fetch_wait_rtype();
    test_beq_jump();
    test_sw_illegal();
    test_rst_mid_memrd();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
